// File: rtl/mdl_bdy_pwm_lanes_pkg.sv
// Shared definitions for the multi-lane pointwise-multiply body.
// Holds the op and FSM encodings, the pipeline tag, the lane/beat helpers
// and the Barrett constant function used by mdl_bdy_pwm_lanes.
package pkg_bdy_pwm;

  typedef enum logic [1:0] {
    OP_PWM = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_A   = 3'd1,
    ST_STREAM_B = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Control bits that travel alongside each beat through the lane pipeline.
  typedef struct packed {
    logic vld;
    logic last;
  } pipe_tag_t;

  function automatic int unsigned lanes_of(input int unsigned daxi, input int unsigned dcoef);
    return daxi / dcoef;
  endfunction

  function automatic int unsigned beats_of(input int unsigned coeffs, input int unsigned lanes);
    return coeffs / lanes;
  endfunction

  // mu = floor(2^(2*qbits) / q); valid for qbits <= 31.
  function automatic logic [63:0] barrett_mu(input int unsigned q, input int unsigned qbits);
    logic [63:0] num;
    num = 64'd1 << (2 * qbits);
    return num / 64'(q);
  endfunction

endpackage

// File: rtl/mdl_bdy_pwm_lanes_modred.sv
// One coefficient lane: a op b mod q over three stall-gated stages.
//   S1 registers the operands, S2 registers the Barrett remainder (< 2q),
//   S3 registers the fully reduced result.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           advance enable (low freezes every stage)
//   op           job op (OP_ADD, OP_SUB, anything else multiplies)
//   q, mu        modulus and its Barrett constant
//   a, b         operands, both < q
//   res          reduced result
module mdl_bdy_modred_lane
  import pkg_bdy_pwm::*;
#(
  parameter int unsigned PRM_QBITS = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             op,
  input  logic [PRM_QBITS-1:0]   q,
  input  logic [2*PRM_QBITS:0]   mu,
  input  logic [PRM_QBITS-1:0]   a,
  input  logic [PRM_QBITS-1:0]   b,
  output logic [PRM_QBITS-1:0]   res
);

  localparam int unsigned QB = PRM_QBITS;
  localparam int unsigned XW = 2 * QB;
  localparam int unsigned MW = 2 * QB + 1;
  localparam int unsigned PW = XW + MW;
  localparam int unsigned RW = QB + 1;

  logic [QB-1:0] a1, b1;
  logic [XW-1:0] x, t, r_full;
  logic [PW-1:0] xm;
  logic [RW-1:0] r2, r_nxt;
  logic [QB-1:0] res_nxt;

  // Operation select; SUB adds q so the value stays non-negative.
  always_comb begin
    x = '0;
    case (op)
      OP_ADD:  x = XW'(a1) + XW'(b1);
      OP_SUB:  x = XW'(a1) + XW'(q) - XW'(b1);
      default: x = XW'(a1) * XW'(b1);
    endcase
  end

  // Barrett: quotient estimate is at most 1 short for x < 2^(2*QB), so r < 2q.
  always_comb begin
    xm     = PW'(x) * PW'(mu);
    t      = XW'(xm >> XW);
    r_full = x - t * XW'(q);
    r_nxt  = RW'(r_full);
  end

  always_comb begin
    res_nxt = QB'(r2);
    if (r2 >= RW'(q)) res_nxt = QB'(r2 - RW'(q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1  <= '0;
      b1  <= '0;
      r2  <= '0;
      res <= '0;
    end else if (en) begin
      a1  <= a;
      b1  <= b;
      r2  <= r_nxt;
      res <= res_nxt;
    end
  end

endmodule

// File: rtl/mdl_bdy_pwm_lanes.sv
// Multi-lane pointwise body: loads polynomial A into a beat buffer, then
// streams B and emits A op B mod q per coefficient, PRM_LANES per beat.
// Ports:
//   iSYS_CLK, iSYS_RST          clock, asynchronous active-low reset
//   iFSM_START                  start pulse (IDLE only)
//   iCTL_OP, iCTL_Q             op and modulus select, latched at start
//   oFSM_DONE                   one-cycle end-of-job pulse
//   oERR                        sticky Tlast framing error
//   iRs_* / oRs_Tready          input AXI-Stream
//   oWm_* / iWm_Tready          output AXI-Stream
//   oPERF_CNT                   busy-cycle counter, only with BDY_PWM_PERF_CNT_EN
module mdl_bdy_pwm_lanes
  import pkg_bdy_pwm::*;
#(
  parameter int unsigned PRM_DAXI   = 64,
  parameter int unsigned PRM_DCOEF  = 32,
  parameter int unsigned PRM_COEFFS = 64,
  parameter int unsigned PRM_QBITS  = 24,
  parameter int unsigned PRM_Q0     = 8380417,
  parameter int unsigned PRM_Q1     = 8404993
) (
  input  logic                iSYS_CLK,
  input  logic                iSYS_RST,
  input  logic                iFSM_START,
  input  logic [1:0]          iCTL_OP,
  input  logic                iCTL_Q,
  output logic                oFSM_DONE,
  output logic                oERR,
`ifdef BDY_PWM_PERF_CNT_EN
  output logic [31:0]         oPERF_CNT,
`endif
  input  logic                iRs_Tvalid,
  output logic                oRs_Tready,
  input  logic [PRM_DAXI-1:0] iRs_Tdata,
  input  logic                iRs_Tlast,
  output logic                oWm_Tvalid,
  input  logic                iWm_Tready,
  output logic [PRM_DAXI-1:0] oWm_Tdata,
  output logic                oWm_Tlast
);

  localparam int unsigned LANES = lanes_of(PRM_DAXI, PRM_DCOEF);
  localparam int unsigned BEATS = beats_of(PRM_COEFFS, LANES);
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned QB    = PRM_QBITS;
  localparam int unsigned MW    = 2 * QB + 1;
  localparam int unsigned UB    = PRM_DCOEF - QB;
  localparam int unsigned RWD   = LANES * QB;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [QB-1:0] QV0       = QB'(PRM_Q0);
  localparam logic [QB-1:0] QV1       = QB'(PRM_Q1);
  localparam logic [MW-1:0] MU0       = MW'(barrett_mu(PRM_Q0, PRM_QBITS));
  localparam logic [MW-1:0] MU1       = MW'(barrett_mu(PRM_Q1, PRM_QBITS));

  state_e          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic            q_sel;
  logic            err;
  pipe_tag_t       tag1, tag2, tag3;

  logic            stall, adv, start_acc, load_acc, strm_acc, beat_last, pipe_empty;
  logic [QB-1:0]   q_cur;
  logic [MW-1:0]   mu_cur;
  logic [RWD-1:0]  in_lanes, a_row, res_lanes;
  logic [LANES*UB-1:0] unused_hi;
  logic [RWD-1:0]  abuf [BEATS];

  assign stall      = tag3.vld & ~iWm_Tready;
  assign adv        = ~stall;
  assign start_acc  = (state == ST_IDLE) & iFSM_START;
  assign load_acc   = (state == ST_LOAD_A) & iRs_Tvalid;
  assign strm_acc   = (state == ST_STREAM_B) & iRs_Tvalid & ~stall;
  assign beat_last  = (cnt == LAST_BEAT);
  assign pipe_empty = ~(tag1.vld | tag2.vld | tag3.vld);
  assign q_cur      = q_sel ? QV1 : QV0;
  assign mu_cur     = q_sel ? MU1 : MU0;
  assign a_row      = abuf[cnt];

  // State register.
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next state; an early Tlast on B cuts the stream short and drains.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (iFSM_START) state_nxt = ST_LOAD_A;
      ST_LOAD_A:   if (load_acc && beat_last) state_nxt = ST_STREAM_B;
      ST_STREAM_B: if (strm_acc && (beat_last || iRs_Tlast)) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (pipe_empty) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    oRs_Tready = 1'b0;
    oFSM_DONE  = 1'b0;
    case (state)
      ST_LOAD_A:   oRs_Tready = 1'b1;
      ST_STREAM_B: oRs_Tready = ~stall;
      ST_DONE:     oFSM_DONE  = 1'b1;
      default:     ;
    endcase
  end

  // Beat counter, job controls and the sticky framing error.
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      cnt   <= '0;
      op_q  <= OP_PWM;
      q_sel <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (start_acc) begin
        cnt   <= '0;
        op_q  <= iCTL_OP;
        q_sel <= iCTL_Q;
        err   <= 1'b0;
      end else if (load_acc || strm_acc) begin
        cnt <= beat_last ? '0 : cnt + CW'(1);
      end
      if (strm_acc && (iRs_Tlast != beat_last)) err <= 1'b1;
    end
  end

  // Pipeline tags; last marks either the final beat or an early-terminated one.
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
    end else if (adv) begin
      tag1 <= '{vld: strm_acc, last: beat_last | iRs_Tlast};
      tag2 <= tag1;
      tag3 <= tag2;
    end
  end

  // A buffer, one row per beat; contents are don't-care after reset.
  always_ff @(posedge iSYS_CLK) begin
    if (load_acc) abuf[cnt] <= in_lanes;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign in_lanes[k*QB +: QB]  = iRs_Tdata[k*PRM_DCOEF +: QB];
    assign unused_hi[k*UB +: UB] = iRs_Tdata[k*PRM_DCOEF+QB +: UB];

    mdl_bdy_modred_lane #(
      .PRM_QBITS (PRM_QBITS)
    ) u_lane (
      .clk   (iSYS_CLK),
      .rst_n (iSYS_RST),
      .en    (adv),
      .op    (op_q),
      .q     (q_cur),
      .mu    (mu_cur),
      .a     (a_row[k*QB +: QB]),
      .b     (in_lanes[k*QB +: QB]),
      .res   (res_lanes[k*QB +: QB])
    );

    assign oWm_Tdata[k*PRM_DCOEF +: PRM_DCOEF] = PRM_DCOEF'(res_lanes[k*QB +: QB]);
  end

  assign oWm_Tvalid = tag3.vld;
  assign oWm_Tlast  = tag3.last;
  assign oERR       = err;

`ifdef BDY_PWM_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Busy-cycle count; holds after DONE until the next start.
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST)              perf_cnt <= '0;
    else if (start_acc)         perf_cnt <= '0;
    else if (state != ST_IDLE)  perf_cnt <= perf_cnt + 32'd1;
  end

  assign oPERF_CNT = perf_cnt;
`endif

endmodule
